mips_bus_arbiter: RTL and testbench

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

---
 rtl/mips_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-port (fetch/data) to single-bus arbiter with an IDLE -> XFER -> ACK handshake.
// Define ARB_ROUND_ROBIN_EN for alternating conflict priority; otherwise the data port always wins.
module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        busy_q, busy_d;
  logic        gnt_data_q, gnt_data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        data_first_s;
  logic        pick_data_s;
  logic        grant_s;

  assign grant_s     = (state_q == ST_IDLE) && (i_req || d_req);
  assign pick_data_s = d_req && (!i_req || data_first_s);

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q = 1 means the data port wins the next conflict; reset favours fetch.
  logic ptr_q, ptr_d;

  assign data_first_s = ptr_q;

  // Pointer next state: after any grant, favour the port that was not granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s) begin
      ptr_d = ~pick_data_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign data_first_s = 1'b1;
`endif

  // Transfer FSM next state and registered bus/requester outputs.
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    busy_d     = busy_q;
    gnt_data_d = gnt_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d    = ST_XFER;
          busy_d     = 1'b1;
          gnt_data_d = pick_data_s;
          if (pick_data_s) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_be;
            write_d = d_we;
            read_d  = ~d_we;
          end else begin
            addr_d  = i_addr;
            be_d    = 4'b1111;
            write_d = 1'b0;
            read_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (!waitrequest) begin
          state_d = ST_ACK;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (gnt_data_q) begin
            d_ack_d = 1'b1;
            if (read_q) begin
              d_rdata_d = readdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = readdata;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      gnt_data_q <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'b0000;
      i_rdata_q  <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      write_q    <= write_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
      gnt_data_q <= gnt_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign read       = read_q;
  assign write      = write_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;
  assign busy       = busy_q;
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Randomized bench for mips_bus_arbiter with a transaction-level reference model.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        busy;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .writedata(writedata), .read(read), .write(write),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int both_strobe_cnt = 0;
  int both_ack_cnt = 0;
  int ack_cnt = 0;
  int grants_m = 0;

  // Reference model: pending requests and what the bus should currently show.
  logic        pend_i = 1'b0, pend_d = 1'b0;
  logic [31:0] m_iaddr, m_daddr, m_dwdata;
  logic [3:0]  m_dbe;
  logic        m_dwe;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, exp_irdata = 32'h0, exp_drdata = 32'h0;
  logic [3:0]  exp_be = 4'h0;
`ifdef ARB_ROUND_ROBIN_EN
  logic        data_turn_m = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string ph, input logic er, input logic ew,
                           input logic eia, input logic eda, input logic eb);
    check_val({ph, ".read"}, {31'b0, read}, {31'b0, er});
    check_val({ph, ".write"}, {31'b0, write}, {31'b0, ew});
    check_val({ph, ".i_ack"}, {31'b0, i_ack}, {31'b0, eia});
    check_val({ph, ".d_ack"}, {31'b0, d_ack}, {31'b0, eda});
    check_val({ph, ".busy"}, {31'b0, busy}, {31'b0, eb});
    check_val({ph, ".address"}, address, exp_addr);
    check_val({ph, ".writedata"}, writedata, exp_wdata);
    check_val({ph, ".byteenable"}, {28'b0, byteenable}, {28'b0, exp_be});
    check_val({ph, ".i_rdata"}, i_rdata, exp_irdata);
    check_val({ph, ".d_rdata"}, d_rdata, exp_drdata);
  endtask

  function automatic logic data_wins();
`ifdef ARB_ROUND_ROBIN_EN
    return pend_d && (!pend_i || data_turn_m);
`else
    return pend_d;
`endif
  endfunction

  task automatic new_fetch(input logic [31:0] a);
    i_req = 1'b1; i_addr = a; m_iaddr = a; pend_i = 1'b1;
  endtask

  task automatic new_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    m_dwe = we; m_daddr = a; m_dwdata = wd; m_dbe = be; pend_d = 1'b1;
  endtask

  // One complete transfer: grant, `stall` wait cycles, completion, ACK.
  task automatic run_txn(input int stall, input logic [31:0] rd);
    logic wd, er, ew;
    wd = data_wins();
`ifdef ARB_ROUND_ROBIN_EN
    data_turn_m = ~wd;
`endif
    if (wd) begin
      exp_addr = m_daddr; exp_wdata = m_dwdata; exp_be = m_dbe; er = ~m_dwe; ew = m_dwe;
    end else begin
      exp_addr = m_iaddr; exp_be = 4'b1111; er = 1'b1; ew = 1'b0;
    end
    waitrequest = 1'($urandom % 2);
    @(posedge clk); #1;
    grants_m++;
    check_bus("grant", er, ew, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < stall; s++) begin
      waitrequest = 1'b1;
      readdata = $urandom;
      if (wd) begin
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
      end else begin
        i_addr = $urandom;
      end
      @(posedge clk); #1;
      check_bus("stall", er, ew, 1'b0, 1'b0, 1'b1);
    end
    waitrequest = 1'b0;
    readdata = rd;
    @(posedge clk); #1;
    readdata = $urandom;
    if (!wd) exp_irdata = rd;
    else if (er) exp_drdata = rd;
    check_bus("done", 1'b0, 1'b0, ~wd, wd, 1'b1);
    if (wd) begin d_req = 1'b0; pend_d = 1'b0; end
    else begin i_req = 1'b0; pend_i = 1'b0; end
    waitrequest = 1'($urandom % 2);
    @(posedge clk); #1;
    check_bus("ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Protocol monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (read && write) both_strobe_cnt <= both_strobe_cnt + 1;
    if (i_ack && d_ack) both_ack_cnt <= both_ack_cnt + 1;
    if (i_ack || d_ack) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = 32'h0; d_addr = 32'h0;
    d_wdata = 32'h0; d_be = 4'h0; d_we = 1'b0; waitrequest = 1'b0; readdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_bus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Boot fetch with no stall.
    new_fetch(32'hBFC0_0000);
    run_txn(0, 32'h2402_0005);

    // Stalled byte-masked write.
    new_data(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    run_txn(3, 32'h1234_5678);

    // Continuous conflict: both requesters re-request immediately after each ack.
    for (int k = 0; k < 6; k++) begin
      if (!pend_i) new_fetch($urandom);
      if (!pend_d) new_data(1'($urandom), $urandom, $urandom, 4'($urandom));
      run_txn($urandom_range(0, 2), $urandom);
    end
    while (pend_i || pend_d) run_txn(0, $urandom);

    // Reset during a stalled transfer aborts it; the held request is re-granted.
    new_fetch($urandom);
    waitrequest = 1'b1;
    @(posedge clk); #1;
    check_val("rst_pre.read", {31'b0, read}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0; exp_irdata = 32'h0; exp_drdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
    data_turn_m = 1'b0;
`endif
    check_bus("rst_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_bus("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run_txn(1, $urandom);

    // Random mix of requests and stalls.
    for (int n = 0; n < 40; n++) begin
      if (!pend_i && ($urandom % 2 == 0)) new_fetch($urandom);
      if (!pend_d && ($urandom % 2 == 0)) new_data(1'($urandom), $urandom, $urandom, 4'($urandom));
      if (!pend_i && !pend_d) begin
        waitrequest = 1'($urandom % 2);
        @(posedge clk); #1;
        check_bus("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        run_txn($urandom_range(0, 5), $urandom);
      end
    end
    while (pend_i || pend_d) run_txn($urandom_range(0, 5), $urandom);

    @(posedge clk); #1;
    check_val("both_strobes", both_strobe_cnt, 32'd0);
    check_val("both_acks", both_ack_cnt, 32'd0);
    check_val("ack_vs_grant", ack_cnt, grants_m);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
